// File: rtl/apb_irq_pkg.sv
// Shared constants for the APB interrupt controller: register offsets (PADDR[4:2]) and event limit.
package apb_irq_pkg;
  localparam int MAX_EVENTS = 32;

  localparam logic [2:0] REG_MASK    = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_SET     = 3'd2;
  localparam logic [2:0] REG_ID      = 3'd3;
endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-set-bit encoder; bit 0 has the highest priority.
// id is 0 whenever no bit is set.
module irq_prio_enc #(
  parameter  int WIDTH = 32,
  localparam int IDW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             valid,
  output logic [IDW-1:0]   id
);

  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        id    = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: edge-detected events latch as pending, are masked and encoded into a registered irq/id.
// Zero wait states. APB_IRQ_SYNC_EN adds a 2-flop input synchroniser (2 extra cycles of event latency).
module apb_irq_ctrl
  import apb_irq_pkg::*;
#(
  parameter  int NUM_EVENTS     = 32,
  parameter  int APB_ADDR_WIDTH = 12,
  localparam int IDW            = $clog2(NUM_EVENTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_EVENTS-1:0]     events_i,
  output logic                      irq_o,
  output logic [IDW-1:0]            irq_id_o,
  input  logic                      irq_ack_i,
  input  logic [IDW-1:0]            irq_ack_id_i
);

  logic [NUM_EVENTS-1:0] ev_in, ev_q, ev_q2, edge_det;
  logic [NUM_EVENTS-1:0] mask_q, pend_q, pend_nxt;
  logic [NUM_EVENTS-1:0] set_wr, clr_wr, ack_hit, active;
  logic                  access, wr;
  logic [2:0]            offs;
  logic                  enc_valid;
  logic [IDW-1:0]        enc_id;
  logic                  unused;

  assign unused = ^{PADDR, PWDATA};

`ifdef APB_IRQ_SYNC_EN
  logic [NUM_EVENTS-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= events_i;
      sync2 <= sync1;
    end
  end

  assign ev_in = sync2;
`else
  assign ev_in = events_i;
`endif

  // History resets low so a line already high at reset release counts as one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q  <= '0;
      ev_q2 <= '0;
    end else begin
      ev_q  <= ev_in;
      ev_q2 <= ev_q;
    end
  end

  assign edge_det = ev_q & ~ev_q2;

  assign access = PSEL & PENABLE;
  assign wr     = access & PWRITE;
  assign offs   = PADDR[4:2];
  assign set_wr = (wr && offs == REG_SET)     ? PWDATA[NUM_EVENTS-1:0] : '0;
  assign clr_wr = (wr && offs == REG_PENDING) ? PWDATA[NUM_EVENTS-1:0] : '0;

  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      ack_hit[i] = irq_ack_i && (irq_ack_id_i == IDW'(i));
    end
  end

  // Set sources win over clear sources arriving in the same cycle.
  assign pend_nxt = (pend_q | edge_det | set_wr) & ~(clr_wr & ~(edge_det | set_wr))
                                                 & ~(ack_hit & ~(edge_det | set_wr));
  assign active   = pend_q & mask_q;

  irq_prio_enc #(.WIDTH(NUM_EVENTS)) u_enc (
    .vec   (active),
    .valid (enc_valid),
    .id    (enc_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= '0;
      pend_q   <= '0;
      irq_o    <= 1'b0;
      irq_id_o <= '0;
    end else begin
      if (wr && offs == REG_MASK) mask_q <= PWDATA[NUM_EVENTS-1:0];
      pend_q   <= pend_nxt;
      irq_o    <= enc_valid;
      irq_id_o <= enc_id;
    end
  end

  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (access) begin
      case (offs)
        REG_MASK:    PRDATA = MAX_EVENTS'(mask_q);
        REG_PENDING: PRDATA = MAX_EVENTS'(pend_q);
        REG_SET:     PRDATA = '0;
        REG_ID:      PRDATA = {irq_o, 26'b0, 5'(irq_id_o)};
        default:     PSLVERR = 1'b1;
      endcase
    end
  end

  assign PREADY = 1'b1;

endmodule
